// File: rtl/multiport_regfile_ff_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multiport_regfile_ff_if
//  Description : Port bundle for the flip-flop physical register file.
//                Bundles read, writeback, allocation and flush signals.
//                The master side drives the inputs of the register file and
//                the slave side is the register file itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multiport_regfile_ff_if #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned NR_RD_PORTS    = 8,
  parameter int unsigned NR_WR_PORTS    = 4,
  parameter int unsigned NR_ALLOC_PORTS = 4
);

  // Read side (issue)
  logic [NR_RD_PORTS-1:0][ADDR_WIDTH-1:0]    raddr_i;
  logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o;
  logic [NR_RD_PORTS-1:0]                    rready_o;

  // Writeback side
  logic [NR_WR_PORTS-1:0]                    we_i;
  logic [NR_WR_PORTS-1:0][ADDR_WIDTH-1:0]    waddr_i;
  logic [NR_WR_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i;

  // Rename-stage allocation and pipeline flush
  logic [NR_ALLOC_PORTS-1:0]                 alloc_i;
  logic [NR_ALLOC_PORTS-1:0][ADDR_WIDTH-1:0] alloc_addr_i;
  logic                                      flush_i;

  modport master (
    output raddr_i,
    output we_i,
    output waddr_i,
    output wdata_i,
    output alloc_i,
    output alloc_addr_i,
    output flush_i,
    input  rdata_o,
    input  rready_o
  );

  modport slave (
    input  raddr_i,
    input  we_i,
    input  waddr_i,
    input  wdata_i,
    input  alloc_i,
    input  alloc_addr_i,
    input  flush_i,
    output rdata_o,
    output rready_o
  );

endinterface
`default_nettype wire

// File: rtl/multiport_regfile_ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multiport_regfile_ff
//  Description : Flip-flop physical register file with NR_RD_PORTS
//                combinational read ports, NR_WR_PORTS synchronous write
//                ports with same-cycle write-to-read bypass, a per-entry
//                ready scoreboard (cleared by allocation, set by writeback,
//                set wholesale by flush) and an optional hardwired zero
//                register at the top address.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiport_regfile_ff #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned NR_RD_PORTS    = 8,
  parameter int unsigned NR_WR_PORTS    = 4,
  parameter int unsigned NR_ALLOC_PORTS = 4,
  parameter bit          ZERO_REG_EN    = 1'b1
) (
  input  wire logic               clk_int,
  input  wire logic               rst_n,
  multiport_regfile_ff_if.slave   rf
);

  localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;

  // The zero register sits at the all-ones address.
  localparam logic [ADDR_WIDTH-1:0] c_zero_addr = {ADDR_WIDTH{1'b1}};

  // Storage: packed so that reset and flush are whole-vector assignments.
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] r_mem;
  logic [NUM_WORDS-1:0]                 r_ready;

  // Write / allocation strobes with zero-register targets already removed.
  logic [NR_WR_PORTS-1:0]               w_wr_keep;
  logic [NR_ALLOC_PORTS-1:0]            w_alloc_keep;

  // Read results before they are driven onto the interface.
  logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0] w_rdata;
  logic [NR_RD_PORTS-1:0]                 w_rready;

  // Drop writes aimed at the hardwired zero register so it never changes.
  always_comb begin
    w_wr_keep = '0;
    for (int p = 0; p < int'(NR_WR_PORTS); p++) begin
      w_wr_keep[p] = rf.we_i[p] &&
                     !(ZERO_REG_EN && (rf.waddr_i[p] == c_zero_addr));
    end
  end

  // Drop allocations aimed at the zero register so it always stays ready.
  always_comb begin
    w_alloc_keep = '0;
    for (int k = 0; k < int'(NR_ALLOC_PORTS); k++) begin
      w_alloc_keep[k] = rf.alloc_i[k] &&
                        !(ZERO_REG_EN && (rf.alloc_addr_i[k] == c_zero_addr));
    end
  end

  // State update. Later assignments in this block override earlier ones, so
  // the statement order encodes the priorities:
  //   writes are issued from the highest port down, leaving the lowest-index
  //   port as the winner on an address conflict;
  //   allocation clears ready after writeback has set it, so allocation wins
  //   the ready bit while the data is still written;
  //   flush comes last and overrides every allocation of the cycle.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_ready <= '1;
    end else begin
      for (int p = int'(NR_WR_PORTS) - 1; p >= 0; p--) begin
        if (w_wr_keep[p]) begin
          r_mem[rf.waddr_i[p]]   <= rf.wdata_i[p];
          r_ready[rf.waddr_i[p]] <= 1'b1;
        end
      end
      for (int k = 0; k < int'(NR_ALLOC_PORTS); k++) begin
        if (w_alloc_keep[k]) begin
          r_ready[rf.alloc_addr_i[k]] <= 1'b0;
        end
      end
      if (rf.flush_i) begin
        r_ready <= '1;
      end
    end
  end

  // Combinational read: zero register first, then same-cycle write bypass
  // (lowest matching port wins), otherwise the stored entry. Bypass is
  // suppressed while reset is asserted so outputs track the cleared storage.
  // Allocations are deliberately not bypassed.
  always_comb begin
    w_rdata  = '0;
    w_rready = '1;
    for (int r = 0; r < int'(NR_RD_PORTS); r++) begin
      if (!(ZERO_REG_EN && (rf.raddr_i[r] == c_zero_addr))) begin
        w_rdata[r]  = r_mem[rf.raddr_i[r]];
        w_rready[r] = r_ready[rf.raddr_i[r]];
        if (rst_n) begin
          for (int p = int'(NR_WR_PORTS) - 1; p >= 0; p--) begin
            if (rf.we_i[p] && (rf.waddr_i[p] == rf.raddr_i[r])) begin
              w_rdata[r]  = rf.wdata_i[p];
              w_rready[r] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign rf.rdata_o  = w_rdata;
  assign rf.rready_o = w_rready;

endmodule
`default_nettype wire

// File: tb/tb_multiport_regfile_ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_multiport_regfile_ff
//  Description : Self-checking bench for multiport_regfile_ff. Directed
//                scenarios followed by randomized traffic checked against a
//                behavioural register-file model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiport_regfile_ff;

  localparam int DW     = 64;
  localparam int AW     = 7;
  localparam int NR     = 8;
  localparam int NW     = 4;
  localparam int NA     = 4;
  localparam int NWORDS = 128;

  logic clk_int = 1'b0;
  logic rst_n   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [DW-1:0] m_mem [NWORDS];
  bit            m_rdy [NWORDS];

  multiport_regfile_ff_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_RD_PORTS(NR),
    .NR_WR_PORTS(NW), .NR_ALLOC_PORTS(NA)
  ) rf_if ();

  multiport_regfile_ff #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_RD_PORTS(NR),
    .NR_WR_PORTS(NW), .NR_ALLOC_PORTS(NA), .ZERO_REG_EN(1'b1)
  ) dut (
    .clk_int (clk_int),
    .rst_n   (rst_n),
    .rf      (rf_if)
  );

  // Free-running clock
  always #5 clk_int = ~clk_int;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rf_if.raddr_i      = '0;
    rf_if.we_i         = '0;
    rf_if.waddr_i      = '0;
    rf_if.wdata_i      = '0;
    rf_if.alloc_i      = '0;
    rf_if.alloc_addr_i = '0;
    rf_if.flush_i      = 1'b0;
  endtask

  task automatic model_reset();
    for (int e = 0; e < NWORDS; e++) begin
      m_mem[e] = '0;
      m_rdy[e] = 1'b1;
    end
  endtask

  // What a read of address a should return given current inputs.
  task automatic model_read(input int a, output logic [DW-1:0] d, output logic rdy);
    bit found = 0;
    d   = m_mem[a];
    rdy = m_rdy[a];
    if (a == NWORDS - 1) begin
      d = '0;
      rdy = 1'b1;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (!found && rf_if.we_i[p] && int'(rf_if.waddr_i[p]) == a) begin
          d = rf_if.wdata_i[p];
          rdy = 1'b1;
          found = 1;
        end
      end
    end
  endtask

  // Entry-by-entry next state from the current inputs.
  task automatic model_edge();
    for (int e = 0; e < NWORDS - 1; e++) begin
      bit written = 0;
      bit alloced = 0;
      for (int p = 0; p < NW; p++) begin
        if (!written && rf_if.we_i[p] && int'(rf_if.waddr_i[p]) == e) begin
          m_mem[e] = rf_if.wdata_i[p];
          written = 1;
        end
      end
      for (int k = 0; k < NA; k++)
        if (rf_if.alloc_i[k] && int'(rf_if.alloc_addr_i[k]) == e) alloced = 1;
      if (rf_if.flush_i)  m_rdy[e] = 1'b1;
      else if (alloced)   m_rdy[e] = 1'b0;
      else if (written)   m_rdy[e] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk_int);
    model_edge();
    #1;
  endtask

  task automatic check_ports_vs_model(input string tag);
    logic [DW-1:0] d;
    logic          rdy;
    for (int r = 0; r < NR; r++) begin
      model_read(int'(rf_if.raddr_i[r]), d, rdy);
      check({tag, "_data"}, rf_if.rdata_o[r], d);
      check({tag, "_rdy"}, {63'd0, rf_if.rready_o[r]}, {63'd0, rdy});
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 7'd127;
    return 7'($urandom_range(0, 15));
  endfunction

  initial begin
    idle();
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk_int);

    // Reset state: every entry 0 and ready
    for (int blk = 0; blk < NWORDS / NR; blk++) begin
      for (int r = 0; r < NR; r++) rf_if.raddr_i[r] = 7'(blk * NR + r);
      #1;
      for (int r = 0; r < NR; r++) begin
        check("rst_data", rf_if.rdata_o[r], 64'd0);
        check("rst_rdy", {63'd0, rf_if.rready_o[r]}, 64'd1);
      end
    end

    // Bypass from port 1, then the same value from storage
    idle();
    rf_if.we_i[1] = 1'b1; rf_if.waddr_i[1] = 7'd5; rf_if.wdata_i[1] = 64'hDEAD_BEEF;
    rf_if.raddr_i[0] = 7'd5;
    #1;
    check("byp_data", rf_if.rdata_o[0], 64'hDEAD_BEEF);
    check("byp_rdy", {63'd0, rf_if.rready_o[0]}, 64'd1);
    step();
    idle(); rf_if.raddr_i[0] = 7'd5; #1;
    check("stor_data", rf_if.rdata_o[0], 64'hDEAD_BEEF);
    check("stor_rdy", {63'd0, rf_if.rready_o[0]}, 64'd1);

    // Conflicting writes: lowest port wins in bypass and storage
    rf_if.we_i[0] = 1'b1; rf_if.waddr_i[0] = 7'd9; rf_if.wdata_i[0] = 64'h11;
    rf_if.we_i[2] = 1'b1; rf_if.waddr_i[2] = 7'd9; rf_if.wdata_i[2] = 64'h22;
    rf_if.raddr_i[1] = 7'd9;
    #1;
    check("conf_byp", rf_if.rdata_o[1], 64'h11);
    step();
    idle(); rf_if.raddr_i[1] = 7'd9; #1;
    check("conf_stor", rf_if.rdata_o[1], 64'h11);

    // Allocation clears ready next cycle
    rf_if.alloc_i[0] = 1'b1; rf_if.alloc_addr_i[0] = 7'd20;
    step();
    idle(); rf_if.raddr_i[0] = 7'd20; #1;
    check("alloc_rdy", {63'd0, rf_if.rready_o[0]}, 64'd0);
    // Write plus allocation to the same entry: bypass ready, then stored not ready
    rf_if.we_i[3] = 1'b1; rf_if.waddr_i[3] = 7'd20; rf_if.wdata_i[3] = 64'h33;
    rf_if.alloc_i[2] = 1'b1; rf_if.alloc_addr_i[2] = 7'd20;
    #1;
    check("wa_byp_data", rf_if.rdata_o[0], 64'h33);
    check("wa_byp_rdy", {63'd0, rf_if.rready_o[0]}, 64'd1);
    step();
    idle(); rf_if.raddr_i[0] = 7'd20; #1;
    check("wa_data", rf_if.rdata_o[0], 64'h33);
    check("wa_rdy", {63'd0, rf_if.rready_o[0]}, 64'd0);

    // Zero register ignores writes and allocations
    rf_if.we_i[0] = 1'b1; rf_if.waddr_i[0] = 7'd127; rf_if.wdata_i[0] = 64'hFF;
    rf_if.alloc_i[1] = 1'b1; rf_if.alloc_addr_i[1] = 7'd127;
    rf_if.raddr_i[2] = 7'd127;
    #1;
    check("zero_byp_data", rf_if.rdata_o[2], 64'd0);
    check("zero_byp_rdy", {63'd0, rf_if.rready_o[2]}, 64'd1);
    step();
    idle(); rf_if.raddr_i[2] = 7'd127; #1;
    check("zero_data", rf_if.rdata_o[2], 64'd0);
    check("zero_rdy", {63'd0, rf_if.rready_o[2]}, 64'd1);

    // Allocate 1..4, then flush with a simultaneous allocation of 6
    for (int k = 0; k < NA; k++) begin
      rf_if.alloc_i[k] = 1'b1; rf_if.alloc_addr_i[k] = 7'(k + 1);
    end
    step();
    idle();
    for (int r = 0; r < 4; r++) rf_if.raddr_i[r] = 7'(r + 1);
    #1;
    for (int r = 0; r < 4; r++) check("pre_flush_rdy", {63'd0, rf_if.rready_o[r]}, 64'd0);
    rf_if.flush_i = 1'b1; rf_if.alloc_i[0] = 1'b1; rf_if.alloc_addr_i[0] = 7'd6;
    step();
    idle();
    for (int r = 0; r < 4; r++) rf_if.raddr_i[r] = 7'(r + 1);
    rf_if.raddr_i[4] = 7'd6; rf_if.raddr_i[5] = 7'd20;
    #1;
    for (int r = 0; r < 6; r++) check("flush_rdy", {63'd0, rf_if.rready_o[r]}, 64'd1);
    check("flush_keep_data", rf_if.rdata_o[5], 64'h33);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < NR; r++) rf_if.raddr_i[r] = rand_addr();
      for (int p = 0; p < NW; p++) begin
        rf_if.we_i[p]    = ($urandom_range(0, 2) == 0);
        rf_if.waddr_i[p] = rand_addr();
        rf_if.wdata_i[p] = {32'($urandom), 32'($urandom)};
      end
      for (int k = 0; k < NA; k++) begin
        rf_if.alloc_i[k]      = ($urandom_range(0, 2) == 0);
        rf_if.alloc_addr_i[k] = rand_addr();
      end
      rf_if.flush_i = ($urandom_range(0, 15) == 0);
      #1;
      check_ports_vs_model("rand");
      step();
    end

    // Reset asserted mid-write: outputs drop to 0/ready at once, write lost
    idle();
    rf_if.we_i[0] = 1'b1; rf_if.waddr_i[0] = 7'd30; rf_if.wdata_i[0] = 64'hABCD;
    rf_if.raddr_i[0] = 7'd30; rf_if.raddr_i[1] = 7'd5; rf_if.raddr_i[2] = 7'd20;
    @(negedge clk_int);
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 3; r++) begin
      check("mid_rst_data", rf_if.rdata_o[r], 64'd0);
      check("mid_rst_rdy", {63'd0, rf_if.rready_o[r]}, 64'd1);
    end
    @(posedge clk_int);
    @(negedge clk_int);
    idle();
    rst_n = 1'b1;
    model_reset();
    rf_if.raddr_i[0] = 7'd30; rf_if.raddr_i[1] = 7'd5; rf_if.raddr_i[2] = 7'd20;
    #1;
    check_ports_vs_model("post_rst");
    check("post_rst_lost", rf_if.rdata_o[0], 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
